tcp_tx_sched: RTL and testbench

TCP_TX_SCHED -- requirements
Module: tcp_tx_sched

---
 rtl/tcp_pkg.sv | 20 ++
 rtl/tcp_tx_sched_if.sv | 42 ++++
 rtl/tcp_tx_sched.sv | 125 ++++++++++++
 tb/tb_tcp_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// tcp_pkg: types shared across the TCP transmit path.
package tcp_pkg;

    // Control segments the TX control block knows how to build.
    typedef enum logic [1:0] {
        TX_CTRL_SEND_SYN = 2'd0,
        TX_CTRL_SEND_ACK = 2'd1,
        TX_CTRL_SEND_FIN = 2'd2,
        TX_CTRL_SEND_RST = 2'd3
    } tx_ctrl_t;

    // Transmit scheduler states, exported so checkers can observe the FSM.
    typedef enum logic [1:0] {
        SCHED_IDLE      = 2'd0,
        SCHED_ISSUE     = 2'd1,
        SCHED_WAIT_DONE = 2'd2,
        SCHED_DATA      = 2'd3
    } tx_sched_state_t;

endpackage

// File: rtl/tcp_tx_sched_if.sv
// tcp_tx_sched_if: request, command and completion signals of the TX scheduler.
// Signal names are written from the scheduler's point of view (i_ in, o_ out).
//
// Handshake rule for every valid/ready or valid/ack pair here: the source
// raises valid and holds it, together with its payload, unchanged until the
// cycle in which the sink's ready/ack is also high; the transfer happens on
// that clock edge and nowhere else. A sink never waits for valid before
// asserting ready.
interface tcp_tx_sched_if;
    import tcp_pkg::*;

    tx_ctrl_t    i_conn_req;
    logic        i_conn_req_valid;
    logic        o_conn_req_ready;
    logic        i_ack_req;
    logic        i_data_avail;
    tx_ctrl_t    o_tx_ctrl;
    logic        o_tx_ctrl_valid;
    logic        i_tx_ctrl_ack;
    logic        o_data_grant;
    logic        i_packet_done;
    logic        o_busy;
    logic        o_timeout;
    logic [15:0] o_pkt_count;

    // The scheduler itself.
    modport slave (
        input  i_conn_req, i_conn_req_valid, i_ack_req, i_data_avail,
               i_tx_ctrl_ack, i_packet_done,
        output o_conn_req_ready, o_tx_ctrl, o_tx_ctrl_valid, o_data_grant,
               o_busy, o_timeout, o_pkt_count
    );

    // The surrounding connection FSM, RX path and TX datapath.
    modport master (
        output i_conn_req, i_conn_req_valid, i_ack_req, i_data_avail,
               i_tx_ctrl_ack, i_packet_done,
        input  o_conn_req_ready, o_tx_ctrl, o_tx_ctrl_valid, o_data_grant,
               o_busy, o_timeout, o_pkt_count
    );

endinterface

// File: rtl/tcp_tx_sched.sv
// tcp_tx_sched: arbitrates between connection control requests, owed ACKs and
// payload packets, keeps one frame in flight at a time, and abandons a frame
// that does not complete within TIMEOUT_CYCLES.
module tcp_tx_sched
    import tcp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    tcp_tx_sched_if.slave   io_sched,
    output tx_sched_state_t o_dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tx_sched_state_t  r_state;
    logic             r_pending_ack;
    logic             r_last_grant;   // 1: last ACK/data arbitration went to ACK
    logic [CNT_W-1:0] r_cnt;

    logic w_in_idle;
    logic w_conn_xfer;
    logic w_pick_ack;
    logic w_pick_data;
    logic w_done_now;
    logic w_expired;
    logic w_retry;
    logic w_ack_clear;
    logic w_pending_nxt;

    assign o_dbg_state = r_state;

    // Grant selection, completion/timeout detection and the pending-ACK update.
    always_comb begin
        w_in_idle   = (r_state == SCHED_IDLE);
        w_conn_xfer = w_in_idle && io_sched.i_conn_req_valid && io_sched.o_conn_req_ready;
        // With both an owed ACK and payload waiting, whichever lost last time wins.
        w_pick_ack  = w_in_idle && !w_conn_xfer && r_pending_ack &&
                      (!io_sched.i_data_avail || !r_last_grant);
        w_pick_data = w_in_idle && !w_conn_xfer && io_sched.i_data_avail &&
                      (!r_pending_ack || r_last_grant);
        // A done pulse only counts once the command was accepted, even if in the same cycle.
        w_done_now  = (((r_state == SCHED_WAIT_DONE) || (r_state == SCHED_DATA)) &&
                       io_sched.i_packet_done) ||
                      ((r_state == SCHED_ISSUE) && io_sched.i_tx_ctrl_ack &&
                       io_sched.i_packet_done);
        w_expired   = !w_in_idle && !w_done_now && (r_cnt == CNT_LAST);
        // An abandoned ACK, or data that would have carried one, must be re-owed.
        w_retry     = (r_state == SCHED_DATA) || (io_sched.o_tx_ctrl == TX_CTRL_SEND_ACK);
        // Any grant that puts an ACK on the wire discharges the owed ACK.
        w_ack_clear = w_pick_ack || w_pick_data ||
                      (w_conn_xfer && (io_sched.i_conn_req == TX_CTRL_SEND_ACK));
        if (w_expired && w_retry) begin
            w_pending_nxt = 1'b1;
        end else begin
            // A new request in the same cycle as a clear must survive.
            w_pending_nxt = (r_pending_ack && !w_ack_clear) || io_sched.i_ack_req;
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state                   <= SCHED_IDLE;
            r_pending_ack             <= 1'b0;
            r_last_grant              <= 1'b0;
            r_cnt                     <= '0;
            io_sched.o_pkt_count      <= '0;
            io_sched.o_tx_ctrl        <= TX_CTRL_SEND_SYN;
            io_sched.o_tx_ctrl_valid  <= 1'b0;
            io_sched.o_data_grant     <= 1'b0;
            io_sched.o_timeout        <= 1'b0;
            io_sched.o_busy           <= 1'b0;
            io_sched.o_conn_req_ready <= 1'b1;
        end else begin
            r_pending_ack      <= w_pending_nxt;
            io_sched.o_timeout <= 1'b0;
            case (r_state)
                SCHED_IDLE: begin
                    if (w_conn_xfer || w_pick_ack || w_pick_data) begin
                        r_cnt                     <= '0;
                        io_sched.o_busy           <= 1'b1;
                        io_sched.o_conn_req_ready <= 1'b0;
                    end
                    if (w_conn_xfer) begin
                        io_sched.o_tx_ctrl       <= io_sched.i_conn_req;
                        io_sched.o_tx_ctrl_valid <= 1'b1;
                        r_state                  <= SCHED_ISSUE;
                    end else if (w_pick_ack) begin
                        io_sched.o_tx_ctrl       <= TX_CTRL_SEND_ACK;
                        io_sched.o_tx_ctrl_valid <= 1'b1;
                        r_last_grant             <= 1'b1;
                        r_state                  <= SCHED_ISSUE;
                    end else if (w_pick_data) begin
                        io_sched.o_data_grant    <= 1'b1;
                        r_last_grant             <= 1'b0;
                        r_state                  <= SCHED_DATA;
                    end
                end
                SCHED_ISSUE, SCHED_WAIT_DONE, SCHED_DATA: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_done_now || w_expired) begin
                        io_sched.o_tx_ctrl_valid  <= 1'b0;
                        io_sched.o_data_grant     <= 1'b0;
                        io_sched.o_busy           <= 1'b0;
                        io_sched.o_conn_req_ready <= 1'b1;
                        r_state                   <= SCHED_IDLE;
                        if (w_done_now) begin
                            io_sched.o_pkt_count <= io_sched.o_pkt_count + 16'd1;
                        end else begin
                            io_sched.o_timeout <= 1'b1;
                        end
                    end else if ((r_state == SCHED_ISSUE) && io_sched.i_tx_ctrl_ack) begin
                        io_sched.o_tx_ctrl_valid <= 1'b0;
                        r_state                  <= SCHED_WAIT_DONE;
                    end
                end
                default: r_state <= SCHED_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx_sched.sv
// tb_tcp_tx_sched: directed bench for the TCP transmit scheduler. A per-cycle
// vector table covers arbitration, coalescing and completion; hand-written
// sequences cover the long SYN handshake, timeout and mid-packet reset.
module tb_tcp_tx_sched;
    import tcp_pkg::*;

    localparam tx_ctrl_t SYN = TX_CTRL_SEND_SYN;
    localparam tx_ctrl_t ACK = TX_CTRL_SEND_ACK;

    logic            clk = 1'b0;
    logic            rst;
    tx_ctrl_t        conn_req;
    logic            conn_valid;
    logic            ack_req;
    logic            data_avail;
    logic            tx_ack;
    logic            pkt_done;
    tx_sched_state_t dbg_state;
    tx_sched_state_t dbg_state_to;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic        cv;
        tx_ctrl_t    cr;
        logic        ar;
        logic        da;
        logic        ta;
        logic        pd;
        logic        e_rdy;
        logic        e_val;
        tx_ctrl_t    e_ctl;
        logic        e_gnt;
        logic        e_busy;
        logic [15:0] e_pkt;
        logic        push;
    } vec_t;

    vec_t vecs[25];

    tcp_tx_sched_if u_if();
    tcp_tx_sched_if u_if_to();

    assign u_if.i_conn_req          = conn_req;
    assign u_if.i_conn_req_valid    = conn_valid;
    assign u_if.i_ack_req           = ack_req;
    assign u_if.i_data_avail        = data_avail;
    assign u_if.i_tx_ctrl_ack       = tx_ack;
    assign u_if.i_packet_done       = pkt_done;
    assign u_if_to.i_conn_req       = conn_req;
    assign u_if_to.i_conn_req_valid = conn_valid;
    assign u_if_to.i_ack_req        = ack_req;
    assign u_if_to.i_data_avail     = data_avail;
    assign u_if_to.i_tx_ctrl_ack    = tx_ack;
    assign u_if_to.i_packet_done    = pkt_done;

    tcp_tx_sched u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_sched    (u_if),
        .o_dbg_state (dbg_state)
    );

    tcp_tx_sched #(.TIMEOUT_CYCLES(8), .CNT_W(4)) u_dut_to (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_sched    (u_if_to),
        .o_dbg_state (dbg_state_to)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int cv, input tx_ctrl_t cr, input int ar, input int da,
                          input int ta, input int pd);
        conn_valid = cv[0];
        conn_req   = cr;
        ack_req    = ar[0];
        data_avail = da[0];
        tx_ack     = ta[0];
        pkt_done   = pd[0];
    endtask

    // Scoreboard the command handshake of the main DUT, then advance one cycle.
    task automatic step();
        if (u_if.o_tx_ctrl_valid && tx_ack) begin
            check("sb_expected_cmd", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("sb_cmd", 32'(u_if.o_tx_ctrl), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, SYN, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input int cv, input tx_ctrl_t cr, input int ar, input int da,
                                input int ta, input int pd, input int e_rdy, input int e_val,
                                input tx_ctrl_t e_ctl, input int e_gnt, input int e_busy,
                                input int e_pkt, input int push);
        vec_t v;
        v.cv = cv[0];       v.cr = cr;          v.ar = ar[0];
        v.da = da[0];       v.ta = ta[0];       v.pd = pd[0];
        v.e_rdy = e_rdy[0]; v.e_val = e_val[0]; v.e_ctl = e_ctl;
        v.e_gnt = e_gnt[0]; v.e_busy = e_busy[0];
        v.e_pkt = e_pkt[15:0];
        v.push = push[0];
        return v;
    endfunction

    initial begin
        int valid_hi;
        int extra;

        //              cv cr  ar da ta pd   rdy val ctl gnt busy pkt push
        vecs[0]  = mk(0, SYN, 1, 0, 0, 0,  1, 0, SYN, 0, 0, 0, 0); // ack owed, nothing granted yet
        vecs[1]  = mk(0, SYN, 0, 1, 0, 0,  0, 1, ACK, 0, 1, 0, 1); // both: ACK wins first
        vecs[2]  = mk(0, SYN, 0, 1, 1, 1,  1, 0, ACK, 0, 0, 1, 0); // ack+done together completes
        vecs[3]  = mk(0, SYN, 1, 0, 0, 0,  1, 0, ACK, 0, 0, 1, 0);
        vecs[4]  = mk(0, SYN, 0, 1, 0, 0,  0, 0, ACK, 1, 1, 1, 0); // both: data wins this time
        vecs[5]  = mk(0, SYN, 0, 0, 0, 1,  1, 0, ACK, 0, 0, 2, 0);
        vecs[6]  = mk(0, SYN, 0, 0, 0, 0,  1, 0, ACK, 0, 0, 2, 0); // ACK piggybacked, none owed
        vecs[7]  = mk(0, SYN, 1, 1, 0, 0,  0, 0, ACK, 1, 1, 2, 0); // data grant + new ack req
        vecs[8]  = mk(0, SYN, 0, 0, 0, 0,  0, 0, ACK, 1, 1, 2, 0); // avail drop keeps grant
        vecs[9]  = mk(0, SYN, 0, 0, 0, 1,  1, 0, ACK, 0, 0, 3, 0);
        vecs[10] = mk(0, SYN, 1, 0, 0, 0,  0, 1, ACK, 0, 1, 3, 1); // ACK grant + ack req
        vecs[11] = mk(0, SYN, 0, 0, 1, 0,  0, 0, ACK, 0, 1, 3, 0);
        vecs[12] = mk(0, SYN, 0, 0, 0, 1,  1, 0, ACK, 0, 0, 4, 0);
        vecs[13] = mk(0, SYN, 0, 0, 0, 0,  0, 1, ACK, 0, 1, 4, 1); // second ACK follows
        vecs[14] = mk(0, SYN, 0, 0, 1, 1,  1, 0, ACK, 0, 0, 5, 0);
        vecs[15] = mk(0, SYN, 0, 0, 0, 0,  1, 0, ACK, 0, 0, 5, 0);
        vecs[16] = mk(1, SYN, 0, 1, 0, 0,  0, 1, SYN, 0, 1, 5, 1); // conn beats data
        vecs[17] = mk(0, SYN, 0, 1, 1, 0,  0, 0, SYN, 0, 1, 5, 0); // no grant in WAIT_DONE
        vecs[18] = mk(0, SYN, 0, 1, 0, 1,  1, 0, SYN, 0, 0, 6, 0);
        vecs[19] = mk(0, SYN, 0, 1, 0, 0,  0, 0, SYN, 1, 1, 6, 0);
        vecs[20] = mk(0, SYN, 0, 0, 0, 1,  1, 0, SYN, 0, 0, 7, 0);
        vecs[21] = mk(0, SYN, 1, 0, 0, 1,  1, 0, SYN, 0, 0, 7, 0); // done in IDLE ignored
        vecs[22] = mk(1, ACK, 0, 0, 0, 0,  0, 1, ACK, 0, 1, 7, 1); // conn ACK coalesces
        vecs[23] = mk(0, SYN, 0, 0, 1, 1,  1, 0, ACK, 0, 0, 8, 0);
        vecs[24] = mk(0, SYN, 0, 0, 0, 0,  1, 0, ACK, 0, 0, 8, 0); // nothing left owed

        // Reset values.
        do_reset();
        check("rst_ready",   32'(u_if.o_conn_req_ready), 1);
        check("rst_valid",   32'(u_if.o_tx_ctrl_valid), 0);
        check("rst_ctrl",    32'(u_if.o_tx_ctrl), 32'(SYN));
        check("rst_grant",   32'(u_if.o_data_grant), 0);
        check("rst_busy",    32'(u_if.o_busy), 0);
        check("rst_timeout", 32'(u_if.o_timeout), 0);
        check("rst_pkt",     32'(u_if.o_pkt_count), 0);
        check("rst_state",   32'(dbg_state), 32'(SCHED_IDLE));

        // SYN held for 4 cycles, accepted, done 10 cycles after the grant.
        set_in(1, SYN, 0, 0, 0, 0);
        step();
        conn_valid = 1'b0;
        check("syn_valid", 32'(u_if.o_tx_ctrl_valid), 1);
        check("syn_ctrl",  32'(u_if.o_tx_ctrl), 32'(SYN));
        check("syn_ready", 32'(u_if.o_conn_req_ready), 0);
        exp_q.push_back(SYN);
        valid_hi = 1;
        for (int c = 1; c <= 10; c++) begin
            tx_ack   = (c == 4);
            pkt_done = (c == 10);
            step();
            if (u_if.o_tx_ctrl_valid) valid_hi++;
            if (c == 5) check("syn_wait_state", 32'(dbg_state), 32'(SCHED_WAIT_DONE));
            if (c == 9) check("syn_ready_busy", 32'(u_if.o_conn_req_ready), 0);
        end
        check("syn_valid_cycles", 32'(valid_hi), 4);
        check("syn_pkt",   32'(u_if.o_pkt_count), 1);
        check("syn_ready_after", 32'(u_if.o_conn_req_ready), 1);
        check("syn_busy_after",  32'(u_if.o_busy), 0);

        // Three ACK requests during SYN collapse into a single SEND_ACK.
        do_reset();
        set_in(1, SYN, 0, 0, 0, 0);
        step();
        exp_q.push_back(SYN);
        for (int c = 1; c <= 6; c++) begin
            set_in(0, SYN, int'(c == 1 || c == 3 || c == 5), 0, int'(c == 2), int'(c == 6));
            step();
        end
        check("coal_idle", 32'(u_if.o_busy), 0);
        check("coal_pkt1", 32'(u_if.o_pkt_count), 1);
        set_in(0, SYN, 0, 0, 0, 0);
        step();
        check("coal_ack_valid", 32'(u_if.o_tx_ctrl_valid), 1);
        check("coal_ack_ctrl",  32'(u_if.o_tx_ctrl), 32'(ACK));
        exp_q.push_back(ACK);
        set_in(0, SYN, 0, 0, 1, 1);
        step();
        check("coal_skip_wait", 32'(dbg_state), 32'(SCHED_IDLE));
        set_in(0, SYN, 0, 0, 0, 0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (u_if.o_tx_ctrl_valid || u_if.o_busy) extra++;
        end
        check("coal_extra_grants", 32'(extra), 0);
        check("coal_pkt2", 32'(u_if.o_pkt_count), 2);

        // Per-cycle vector table.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            set_in(int'(vecs[i].cv), vecs[i].cr, int'(vecs[i].ar), int'(vecs[i].da),
                   int'(vecs[i].ta), int'(vecs[i].pd));
            step();
            if (vecs[i].push) exp_q.push_back(vecs[i].e_ctl);
            check($sformatf("v%0d_ready", i), 32'(u_if.o_conn_req_ready), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d_valid", i), 32'(u_if.o_tx_ctrl_valid), 32'(vecs[i].e_val));
            check($sformatf("v%0d_ctrl", i),  32'(u_if.o_tx_ctrl), 32'(vecs[i].e_ctl));
            check($sformatf("v%0d_grant", i), 32'(u_if.o_data_grant), 32'(vecs[i].e_gnt));
            check($sformatf("v%0d_busy", i),  32'(u_if.o_busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_timeout", i), 32'(u_if.o_timeout), 0);
            check($sformatf("v%0d_pkt", i),   32'(u_if.o_pkt_count), 32'(vecs[i].e_pkt));
        end

        // Timeout after 8 cycles on the short-timeout instance, ACK retried.
        do_reset();
        set_in(0, SYN, 1, 0, 0, 0);
        step();
        set_in(0, SYN, 0, 0, 0, 0);
        step();
        check("to_issue_valid", 32'(u_if_to.o_tx_ctrl_valid), 1);
        check("to_issue_ctrl",  32'(u_if_to.o_tx_ctrl), 32'(ACK));
        exp_q.push_back(ACK);
        for (int c = 1; c <= 8; c++) begin
            tx_ack = (c == 1);
            step();
            check($sformatf("to_pulse_c%0d", c), 32'(u_if_to.o_timeout), 32'(c == 8));
        end
        check("to_busy",   32'(u_if_to.o_busy), 0);
        check("to_valid",  32'(u_if_to.o_tx_ctrl_valid), 0);
        check("to_pkt",    32'(u_if_to.o_pkt_count), 0);
        check("to_main_no_timeout", 32'(u_if.o_timeout), 0);
        check("to_main_still_busy", 32'(u_if.o_busy), 1);
        tx_ack = 1'b0;
        step();
        check("to_pulse_end",  32'(u_if_to.o_timeout), 0);
        check("to_retry_valid", 32'(u_if_to.o_tx_ctrl_valid), 1);
        check("to_retry_ctrl",  32'(u_if_to.o_tx_ctrl), 32'(ACK));

        // Reset while a data packet is in flight, conn request held through reset.
        do_reset();
        set_in(0, SYN, 0, 1, 0, 0);
        step();
        check("rd_grant1", 32'(u_if.o_data_grant), 1);
        set_in(0, SYN, 0, 1, 0, 1);
        step();
        check("rd_pkt1", 32'(u_if.o_pkt_count), 1);
        set_in(0, SYN, 0, 1, 0, 0);
        step();
        set_in(0, SYN, 0, 0, 0, 0);
        step();
        check("rd_in_data", 32'(dbg_state), 32'(SCHED_DATA));
        rst = 1'b1;
        set_in(1, SYN, 0, 0, 0, 0);
        step();
        check("rd_grant_drop", 32'(u_if.o_data_grant), 0);
        check("rd_pkt_clear",  32'(u_if.o_pkt_count), 0);
        check("rd_no_timeout", 32'(u_if.o_timeout), 0);
        check("rd_busy",       32'(u_if.o_busy), 0);
        check("rd_ready",      32'(u_if.o_conn_req_ready), 1);
        step();
        check("rd_no_accept_in_reset", 32'(u_if.o_tx_ctrl_valid), 0);
        rst = 1'b0;
        step();
        conn_valid = 1'b0;
        check("rd_accept_valid", 32'(u_if.o_tx_ctrl_valid), 1);
        check("rd_accept_ctrl",  32'(u_if.o_tx_ctrl), 32'(SYN));
        check("rd_accept_ready", 32'(u_if.o_conn_req_ready), 0);
        exp_q.push_back(SYN);
        set_in(0, SYN, 0, 0, 1, 1);
        step();
        check("rd_final_pkt", 32'(u_if.o_pkt_count), 1);
        set_in(0, SYN, 0, 0, 0, 0);
        step();

        // Report.
        check("sb_drain", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
